// File: rtl/board_pin_receiver.sv
// Receiving end of the 8-pin gameboard link: synchronizes the pin bus and strobe,
// assembles header/data/checksum frames and publishes the last good board.
module board_pin_receiver #(
  parameter int         BOARD_BYTES    = 2,
  parameter logic [7:0] HEADER         = 8'hC4,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               pin_data,
  input  logic                     pin_strobe,
  output logic [8*BOARD_BYTES-1:0] gameboard,
  output logic                     board_valid,
  output logic                     frame_error,
  output logic                     busy
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int IDX_W   = (BOARD_BYTES > 1) ? $clog2(BOARD_BYTES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(BOARD_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t                   state;
  logic                     strobe_meta;
  logic                     strobe_sync;
  logic                     strobe_prev;
  logic [7:0]               data_meta;
  logic [7:0]               data_sync;
  logic [8*BOARD_BYTES-1:0] shift_reg;
  logic [IDX_W-1:0]         idx;
  logic [7:0]               xor_acc;
  logic [TIMER_W-1:0]       timer;
  logic                     strobe_edge;

  // NOTE: a 2-FF synchronizer on a multi-bit bus is only safe because the sender
  // holds pin_data stable for several clocks around the strobe; the strobe edge,
  // seen two stages later, always finds a settled byte in data_sync.
  assign strobe_edge = strobe_sync & ~strobe_prev;
  assign busy        = (state != IDLE);

  // NOTE: every register, including synchronizer stages and the board word, is
  // cleared by the synchronous reset; there is no memory array here to exempt.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_meta <= 1'b0;
      strobe_sync <= 1'b0;
      strobe_prev <= 1'b0;
      data_meta   <= '0;
      data_sync   <= '0;
      state       <= IDLE;
      shift_reg   <= '0;
      idx         <= '0;
      xor_acc     <= '0;
      timer       <= '0;
      gameboard   <= '0;
      board_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      strobe_meta <= pin_strobe;
      strobe_sync <= strobe_meta;
      strobe_prev <= strobe_sync;
      data_meta   <= pin_data;
      data_sync   <= data_meta;
      board_valid <= 1'b0;
      frame_error <= 1'b0;

      case (state)
        IDLE: begin
          if (strobe_edge && data_sync == HEADER) begin
            state   <= DATA;
            idx     <= '0;
            xor_acc <= '0;
            timer   <= '0;
          end
        end

        DATA, CHECK: begin
          // A strobe arriving in the expiry cycle is served; the timeout only
          // fires when no edge shows up in time.
          if (strobe_edge) begin
            timer <= '0;
            if (state == DATA) begin
              shift_reg[8*idx +: 8] <= data_sync;
              xor_acc               <= xor_acc ^ data_sync;
              idx                   <= idx + 1'b1;
              if (idx == IDX_LAST) state <= CHECK;
            end else begin
              if (data_sync == xor_acc) begin
                gameboard   <= shift_reg;
                board_valid <= 1'b1;
              end else begin
                frame_error <= 1'b1;
              end
              state <= IDLE;
            end
          end else if (timer == TIMER_LAST) begin
            frame_error <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
